// File: rtl/hb_down2_if.sv
// Sample stream bundle for the half-band decimator: qualified input samples in,
// decimated samples with overflow flag out.
interface hb_down2_if #(
    parameter int XIN_WIDTH  = 16,
    parameter int YOUT_WIDTH = 16
);
    logic signed [XIN_WIDTH-1:0]  xin;
    logic                         xin_valid;
    logic signed [YOUT_WIDTH-1:0] yout;
    logic                         yout_valid;
    logic                         ovf;

    modport master (output xin, xin_valid, input yout, yout_valid, ovf);
    modport slave  (input xin, xin_valid, output yout, yout_valid, ovf);
endinterface

// File: rtl/hb_down2.sv
// Half-band decimate-by-2 FIR sharing the interpolator's unique-coefficient table.
// Four-stage free-running valid-tagged pipeline: pre-add, multiply, sum, round/saturate.
module hb_down2 #(
    parameter int XIN_WIDTH      = 16,
    parameter int COE_WIDTH      = 16,
    parameter int NUM_UNIQUE_COE = 5,
    parameter logic signed [COE_WIDTH-1:0] COE_NUMS [NUM_UNIQUE_COE] =
        '{16'sd952, -16'sd1609, 16'sd3090, -16'sd6260, 16'sd20622},
    parameter int YOUT_WIDTH     = 16,
    parameter int SRA_BITS       = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    hb_down2_if.slave   bus
);
    localparam int N      = NUM_UNIQUE_COE;
    localparam int TAPS   = 4 * N - 1;
    localparam int CTR    = 2 * N - 1;
    localparam int PRE_W  = XIN_WIDTH + 1;
    localparam int PROD_W = XIN_WIDTH + COE_WIDTH + 1;
    localparam int ACC_W  = XIN_WIDTH + COE_WIDTH + 2 + $clog2(N + 1);

    localparam logic signed [ACC_W-1:0] HALF =
        {{(ACC_W-SRA_BITS-1){1'b0}}, 1'b1, {SRA_BITS{1'b0}}};
    localparam logic signed [ACC_W-1:0] YMAX =
        {{(ACC_W-YOUT_WIDTH+1){1'b0}}, {(YOUT_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] YMIN =
        {{(ACC_W-YOUT_WIDTH+1){1'b1}}, {(YOUT_WIDTH-1){1'b0}}};

    // Odd distance from the centre tap for unique coefficient i (outermost first).
    function automatic int tap_off(input int i);
        return 2 * (N - 1 - i) + 1;
    endfunction

    // Round half up while dropping the coefficient fraction plus the decimation gain of 2.
    function automatic logic signed [ACC_W-1:0] round_shift(input logic signed [ACC_W-1:0] v);
        return (v + HALF) >>> (SRA_BITS + 1);
    endfunction

    // Returns {ovf, clipped sample}.
    function automatic logic [YOUT_WIDTH:0] saturate(input logic signed [ACC_W-1:0] v);
        if (v > YMAX)
            return {1'b1, 1'b0, {(YOUT_WIDTH-1){1'b1}}};
        else if (v < YMIN)
            return {1'b1, 1'b1, {(YOUT_WIDTH-1){1'b0}}};
        else
            return {1'b0, v[YOUT_WIDTH-1:0]};
    endfunction

    // ---- p0: delay line, phase tracking, output trigger ----
    logic signed [XIN_WIDTH-1:0] r_xd [TAPS];
    logic                        r_phase;
    logic                        r_vld_p0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < TAPS; k++) r_xd[k] <= '0;
            r_phase  <= 1'b0;
            r_vld_p0 <= 1'b0;
        end else begin
            r_vld_p0 <= bus.xin_valid & ~r_phase;
            if (bus.xin_valid) begin
                r_xd[0] <= bus.xin;
                for (int k = 1; k < TAPS; k++) r_xd[k] <= r_xd[k-1];
                r_phase <= ~r_phase;
            end
        end
    end

    // ---- p1: symmetric pre-add ----
    logic signed [PRE_W-1:0]     r_pre_p1 [N];
    logic signed [XIN_WIDTH-1:0] r_ctr_p1;
    logic                        r_vld_p1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) r_pre_p1[i] <= '0;
            r_ctr_p1 <= '0;
            r_vld_p1 <= 1'b0;
        end else begin
            for (int i = 0; i < N; i++)
                r_pre_p1[i] <= PRE_W'(r_xd[CTR - tap_off(i)]) + PRE_W'(r_xd[CTR + tap_off(i)]);
            r_ctr_p1 <= r_xd[CTR];
            r_vld_p1 <= r_vld_p0;
        end
    end

    // ---- p2: coefficient multiply; centre tap is a pure shift ----
    logic signed [PROD_W-1:0] r_prod_p2 [N];
    logic signed [ACC_W-1:0]  r_ctr_p2;
    logic                     r_vld_p2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) r_prod_p2[i] <= '0;
            r_ctr_p2 <= '0;
            r_vld_p2 <= 1'b0;
        end else begin
            for (int i = 0; i < N; i++)
                r_prod_p2[i] <= PROD_W'(COE_NUMS[i]) * PROD_W'(r_pre_p1[i]);
            r_ctr_p2 <= ACC_W'(r_ctr_p1) <<< SRA_BITS;
            r_vld_p2 <= r_vld_p1;
        end
    end

    // ---- p3: accumulate ----
    logic signed [ACC_W-1:0] w_sum;
    logic signed [ACC_W-1:0] r_acc_p3;
    logic                    r_vld_p3;

    always_comb begin
        w_sum = r_ctr_p2;
        for (int i = 0; i < N; i++) w_sum = w_sum + ACC_W'(r_prod_p2[i]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc_p3 <= '0;
            r_vld_p3 <= 1'b0;
        end else begin
            r_acc_p3 <= w_sum;
            r_vld_p3 <= r_vld_p2;
        end
    end

    // ---- p4: round, saturate, hold between strobes ----
    logic [YOUT_WIDTH:0]          w_sat;
    logic signed [YOUT_WIDTH-1:0] r_yout_p4;
    logic                         r_ovf_p4;
    logic                         r_vld_p4;

    assign w_sat = saturate(round_shift(r_acc_p3));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_yout_p4 <= '0;
            r_ovf_p4  <= 1'b0;
            r_vld_p4  <= 1'b0;
        end else begin
            r_vld_p4 <= r_vld_p3;
            if (r_vld_p3) begin
                r_yout_p4 <= w_sat[YOUT_WIDTH-1:0];
                r_ovf_p4  <= w_sat[YOUT_WIDTH];
            end
        end
    end

    assign bus.yout       = r_yout_p4;
    assign bus.ovf        = r_ovf_p4;
    assign bus.yout_valid = r_vld_p4;
endmodule
